aes_key_sched: RTL and testbench
================================

AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter NK, default 4, key length in 32-bit words; legal values 4, 6 and 8 (AES-128/192/256); round count NR = NK+6.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port Start, input, 1 bit, a request to begin key expansion.
REQ-005 SHALL have port Key, input, 32*NK bits, the cipher key; word w0 = Key[32*NK-1 -: 32], per FIPS-197 byte order.
REQ-006 SHALL have port SelKey, input, 4 bits, the round-key index 0..NR.
REQ-007 SHALL have port RoundKey, output, 128 bits, the round key for SelKey.
REQ-008 SHALL have port Busy, output, 1 bit, high while expansion is in progress.
REQ-009 SHALL have port Ry, output, 1 bit, high when all round keys are valid.

Function
REQ-010 SHALL implement the states IDLE, EXPAND and DONE.
REQ-011 SHALL, in IDLE or DONE, when Start=1 at a clock edge, write w0..w(NK-1) from Key into storage, set word index i=NK and the Rcon register to 8'h01, and enter EXPAND.
REQ-012 SHALL, in EXPAND, compute and store exactly one word w[i] per clock: w[i] = w[i-NK] xor temp.
REQ-013 SHALL form temp from w[i-1] as follows: if i mod NK = 0, temp = SubWord(RotWord(w[i-1])) xor {Rcon,24'h0}, after which Rcon advances by xtime (GF(2^8) doubling, poly 0x11B); if NK=8 and i mod 8 = 4, temp = SubWord(w[i-1]); otherwise temp = w[i-1].
REQ-014 SHALL implement SubWord with the FIPS-197 forward S-box, using one shared instance of four byte S-boxes.
REQ-015 SHALL, when the last word w[4*NR+3] is written, leave EXPAND and enter DONE.
REQ-016 SHALL have latency from the Start edge to Ry=1 of 4*NR+4-NK clock edges: 40 for NK=4, 46 for NK=6, 52 for NK=8.
REQ-017 SHALL hold Busy=1 exactly while in EXPAND, and Ry=1 exactly while in DONE.
REQ-018 SHALL ignore Start while in EXPAND; the expansion in progress completes unchanged.
REQ-019 SHALL, on Start in DONE, drop Ry on that edge and restart expansion with the new Key.
REQ-020 SHALL drive RoundKey combinationally from storage as {w[4s], w[4s+1], w[4s+2], w[4s+3]}, where s = SelKey.
REQ-021 SHALL drive RoundKey to zero when SelKey > NR.
REQ-022 SHALL make RoundKey contents undefined for reading unless Ry=1.
REQ-023 SHALL treat Key as sampled only at the Start edge; later changes to Key have no effect.
REQ-024 SHALL flag an NK other than 4, 6 or 8 at elaboration; the illegal value does not synthesise.

Reset
REQ-025 SHALL, while Rst=0, force state IDLE, Busy=0, Ry=0, i=0, Rcon=8'h01 and all storage words to zero, asynchronously.
REQ-026 SHALL treat Rst asserted mid-EXPAND as an abort: no partial Ry, and a fresh Start is required after release.
REQ-027 SHALL, after Rst is released, leave RoundKey = 0 for every SelKey until the first Start.

Configuration
REQ-028 SHALL, with macro AES_KSCHED_ROWMAJOR_EN defined, present RoundKey in transposed (row-major state) order: byte r of word c is placed at RoundKey[127-8*(4*r+c) -: 8].
REQ-029 SHALL, without AES_KSCHED_ROWMAJOR_EN, present RoundKey in FIPS-197 word order per REQ-020; storage and timing are identical in both builds.

Verification
REQ-030 SHALL cover the NK=4 default build: Key=2b7e151628aed2a6abf7158809cf4f3c, Start pulse -> Ry=1 after 40 clocks; SelKey=1 gives a0fafe1788542cb123a339392a6c7605; SelKey=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 SHALL cover the NK=4 build with AES_KSCHED_ROWMAJOR_EN and the same Key: SelKey=10 gives d0c9e1b614ee3f63f9250c0ca889c8a6; SelKey=0 gives 2b28ab097eaef7cf15d2154f16a6883c.
REQ-032 SHALL cover NK=8: Key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> Ry=1 after 52 clocks; SelKey=14 gives fe4890d1e6188d0b046df344706c631e; SelKey=15 gives 0.
REQ-033 SHALL cover NK=6: Key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> Ry=1 after 46 clocks; SelKey=12 gives e98ba06f448c773c8ecc720401002202.
REQ-034 SHALL cover Start re-pulsed with a different Key at clock 20 of EXPAND -> ignored; the first key's results appear at clock 40.
REQ-035 SHALL cover Rst=0 at clock 15 of EXPAND -> Busy=0, Ry=0 and RoundKey=0 immediately; a subsequent Start produces correct keys.

Source files
------------

// File: rtl/aes_key_sched.sv
// AES key expansion engine for AES-128/192/256 (NK = 4/6/8).
// Produces one expanded word per clock into an internal word store.
// Any round key can then be read combinationally by index.
// Optional build macro AES_KSCHED_ROWMAJOR_EN changes the RoundKey output order.
// When the macro is defined, RoundKey is the transposed (row-major state) layout.
// When it is undefined, RoundKey uses FIPS-197 word order.
module aes_key_sched #(
    parameter int NK = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    input  logic [32*NK-1:0] Key,
    input  logic [3:0]      SelKey,
    output logic [127:0]    RoundKey,
    output logic            Busy,
    output logic            Ry
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    // Only the three AES key lengths are meaningful; anything else stops elaboration.
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_key_sched: NK must be 4, 6 or 8");
    end

    // FIPS-197 forward S-box, row-major: entry b sits at SBOX[2047-8*b -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t      state;
    logic [31:0] w [NW];
    logic [5:0]  idx;        // index i of the next word to be produced
    logic [2:0]  phase;      // i mod NK, tracked incrementally to avoid a divider
    logic [7:0]  rcon;

    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [7:0]  rcon_next;
    logic [127:0] sel_words;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // Next-word datapath: the single shared four-byte S-box feeds both RotWord and plain SubWord cases.
    // NOTE: every combinational output gets a default value first, so no path can infer a latch.
    always_comb begin
        prev_word = w[idx - 6'd1];
        back_word = w[idx - 6'(NK)];
        sub_in    = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                     sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        temp      = prev_word;
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h000000};
        end else if ((NK == 8) && (phase == 3'd4)) begin
            temp = sub_out;
        end
    end

    // Control FSM and word store: load the key on Start, then produce one word per clock until w[NW-1].
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
            Busy  <= 1'b0;
            Ry    <= 1'b0;
            // NOTE: the word store is reset on purpose, so RoundKey reads zero after reset.
            for (int k = 0; k < NW; k++) begin
                w[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        for (int k = 0; k < NK; k++) begin
                            w[k] <= Key[32*(NK-1-k) +: 32];
                        end
                        idx   <= 6'(NK);
                        phase <= '0;
                        rcon  <= 8'h01;
                        Busy  <= 1'b1;
                        Ry    <= 1'b0;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    w[idx] <= back_word ^ temp;
                    if (phase == 3'd0) begin
                        rcon <= rcon_next;
                    end
                    phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    idx   <= idx + 6'd1;
                    if (idx == 6'(NW - 1)) begin
                        Busy  <= 1'b0;
                        Ry    <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Ry    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Round-key read port: four consecutive words, or zero for an index beyond the last round.
    always_comb begin
        sel_words = '0;
        if (SelKey <= 4'(NR)) begin
            sel_words = {w[{SelKey, 2'b00}],         w[{SelKey, 2'b00} + 6'd1],
                         w[{SelKey, 2'b00} + 6'd2],  w[{SelKey, 2'b00} + 6'd3]};
        end
`ifdef AES_KSCHED_ROWMAJOR_EN
        // Transposed output: byte r of word c lands in state row r, column c.
        RoundKey = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                RoundKey[127 - 8*(4*r + c) -: 8] = sel_words[127 - 8*(4*c + r) -: 8];
            end
        end
`else
        RoundKey = sel_words;
`endif
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched.
// Three instances (NK = 4, 6, 8) run against FIPS-197 reference vectors.
// Expected round keys go into a scoreboard queue when expansion is started.
// The entries are popped and compared once Ry rises.
// Honours AES_KSCHED_ROWMAJOR_EN by transposing the expected values.
module tb_aes_key_sched;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         Clk;
    logic         Rst;
    logic         start4, start6, start8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [3:0]   sel4, sel6, sel8;
    logic [127:0] rk4, rk6, rk8;
    logic         busy4, busy6, busy8;
    logic         ry4, ry6, ry8;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int           inst;
        logic [3:0]   sel;
        logic [127:0] exp;
        string        tag;
    } sb_t;

    sb_t sb_q[$];

    aes_key_sched #(.NK(4)) u_dut4 (.Clk(Clk), .Rst(Rst), .Start(start4), .Key(key4), .SelKey(sel4),
                                    .RoundKey(rk4), .Busy(busy4), .Ry(ry4));
    aes_key_sched #(.NK(6)) u_dut6 (.Clk(Clk), .Rst(Rst), .Start(start6), .Key(key6), .SelKey(sel6),
                                    .RoundKey(rk6), .Busy(busy6), .Ry(ry6));
    aes_key_sched #(.NK(8)) u_dut8 (.Clk(Clk), .Rst(Rst), .Start(start8), .Key(key8), .SelKey(sel8),
                                    .RoundKey(rk8), .Busy(busy8), .Ry(ry8));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected-value layout for the build under test.
    function automatic logic [127:0] xf(input logic [127:0] v);
`ifdef AES_KSCHED_ROWMAJOR_EN
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[127 - 8*(4*r + c) -: 8] = v[127 - 8*(4*c + r) -: 8];
            end
        end
        return t;
`else
        return v;
`endif
    endfunction

    function automatic logic [127:0] rk_of(input int inst);
        case (inst)
            6:       return rk6;
            8:       return rk8;
            default: return rk4;
        endcase
    endfunction

    function automatic logic ry_of(input int inst);
        case (inst)
            6:       return ry6;
            8:       return ry8;
            default: return ry4;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            6:       return busy6;
            8:       return busy8;
            default: return busy4;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int inst, input logic [3:0] s);
        case (inst)
            6:       sel6 = s;
            8:       sel8 = s;
            default: sel4 = s;
        endcase
    endtask

    // Single-cycle Start pulse carrying the key; returns just after the Start edge.
    task automatic start_pulse(input int inst, input logic [255:0] k);
        case (inst)
            6:       begin key6 = k[191:0]; start6 = 1'b1; end
            8:       begin key8 = k;        start8 = 1'b1; end
            default: begin key4 = k[127:0]; start4 = 1'b1; end
        endcase
        tick();
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic push(input int inst, input logic [3:0] s, input logic [127:0] v, input string tag);
        sb_t e;
        e.inst = inst;
        e.sel  = s;
        e.exp  = xf(v);
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Count edges until Ry, bounded; the edge count is compared with the required latency.
    task automatic wait_ready(input int inst, input int lat, input int already, input string tag);
        int n;
        n = already;
        while (!ry_of(inst) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_busy_done"}, {127'b0, busy_of(inst)}, 128'd0);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            set_sel(e.inst, e.sel);
            #1;
            check(e.tag, rk_of(e.inst), e.exp);
        end
    endtask

    task automatic push_aes128(input string pfx);
        push(4, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, {pfx, "_rk0"});
        push(4, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, {pfx, "_rk1"});
        push(4, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, {pfx, "_rk2"});
        push(4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, {pfx, "_rk10"});
        push(4, 4'd11, 128'h0, {pfx, "_rk11_zero"});
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst    = 1'b0;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4   = '0;   key6   = '0;   key8   = '0;
        sel4   = 4'd0; sel6   = 4'd0; sel8   = 4'd0;
        tick();
        tick();

        // Reset state, then zero round keys before the first Start.
        check("rst_busy", {127'b0, busy4}, 128'd0);
        check("rst_ry",   {127'b0, ry4},   128'd0);
        Rst = 1'b1;
        tick();
        sel4 = 4'd10; sel8 = 4'd14;
        #1;
        check("post_rst_rk4_sel10", rk4, 128'd0);
        check("post_rst_rk8_sel14", rk8, 128'd0);

        // AES-128 expansion; Key is changed right after Start and must not matter.
        start_pulse(4, 256'(KEY128));
        check("k128_busy_start", {127'b0, busy4}, 128'd1);
        key4 = ~KEY128;
        push_aes128("k128");
        push(4, 4'd15, 128'h0, "k128_rk15_zero");
        wait_ready(4, 40, 0, "k128");
        drain();

        // AES-256 expansion.
        start_pulse(8, KEY256);
        push(8, 4'd0,  KEY256[255:128], "k256_rk0");
        push(8, 4'd1,  KEY256[127:0],   "k256_rk1");
        push(8, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "k256_rk14");
        push(8, 4'd15, 128'h0, "k256_rk15_zero");
        wait_ready(8, 52, 0, "k256");
        drain();

        // AES-192 expansion.
        start_pulse(6, 256'(KEY192));
        push(6, 4'd0,  KEY192[191:64], "k192_rk0");
        push(6, 4'd12, 128'he98ba06f448c773c8ecc720401002202, "k192_rk12");
        push(6, 4'd13, 128'h0, "k192_rk13_zero");
        wait_ready(6, 46, 0, "k192");
        drain();

        // Reset asserted at clock 15 of an expansion aborts it and clears the store at once.
        start_pulse(4, 256'(KEY128));
        repeat (15) tick();
        sel4 = 4'd1;
        Rst  = 1'b0;
        #1;
        check("abort_busy", {127'b0, busy4}, 128'd0);
        check("abort_ry",   {127'b0, ry4},   128'd0);
        check("abort_rk1",  rk4, 128'd0);
        tick();
        Rst = 1'b1;
        repeat (3) tick();
        check("abort_no_resume", {126'b0, busy4, ry4}, 128'd0);

        // Start re-pulsed with another key at clock 20 of expansion is ignored.
        start_pulse(4, 256'(KEY128));
        push_aes128("ign");
        repeat (19) tick();
        key4   = KEY256[127:0];
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("ign_busy_still", {127'b0, busy4}, 128'd1);
        wait_ready(4, 40, 20, "ign");
        drain();

        // Start in DONE drops Ry on that edge and re-expands.
        start_pulse(4, 256'(KEY128));
        check("restart_ry_drop", {126'b0, busy4, ry4}, 128'd2);
        push(4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_rk10");
        wait_ready(4, 40, 0, "restart");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
